// File: rtl/mac_seq_pkg.sv
// mac_seq_pkg: shared constants, FSM state type and the 24-bit saturation helper
// for the mac_seq dot-product sequencer.
package mac_seq_pkg;

  localparam int F_W     = 12;
  localparam int ACC_W   = 24;
  localparam int RES_W   = 25;
  localparam int LEN_W   = 5;
  localparam int ENTRY_W = 2 * F_W;

  // Register byte offsets.
  localparam int CTRL_OFF   = 'h000;
  localparam int STATUS_OFF = 'h008;
  localparam int LEN_OFF    = 'h010;
  localparam int INIT_OFF   = 'h018;
  localparam int ACC_OFF    = 'h020;
  localparam int BUF_BASE   = 'h100;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_CAPTURE,
    S_DONE
  } state_e;

  typedef struct packed {
    logic             ovf;
    logic [ACC_W-1:0] val;
  } sat_t;

  // Clamp a 25-bit signed mac result into 24 bits. The value is out of range
  // exactly when the top two bits disagree; the sign bit picks the rail.
  function automatic sat_t sat24(input logic [RES_W-1:0] x);
    sat_t r;
    r.ovf = x[RES_W-1] ^ x[RES_W-2];
    if (!r.ovf) begin
      r.val = x[ACC_W-1:0];
    end else if (x[RES_W-1]) begin
      r.val = {1'b1, {(ACC_W-1){1'b0}}};
    end else begin
      r.val = {1'b0, {(ACC_W-1){1'b1}}};
    end
    return r;
  endfunction

endpackage

// File: rtl/mac_seq_opbuf.sv
// mac_seq_opbuf: DEPTH x 24-bit operand register file ({f2, f1} per entry).
// One write port from the CSR side, two combinational read ports: CSR readback
// and the sequencer's current element.
module mac_seq_opbuf
  import mac_seq_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int IDX_W = 4
) (
  input  logic               clk,
  input  logic               arst,
  input  logic               we,
  input  logic [IDX_W-1:0]   waddr,
  input  logic [ENTRY_W-1:0] wdata,
  input  logic [IDX_W-1:0]   csr_raddr,
  output logic [ENTRY_W-1:0] csr_rdata,
  input  logic [IDX_W-1:0]   seq_raddr,
  output logic [ENTRY_W-1:0] seq_rdata
);

  logic [ENTRY_W-1:0] mem_q [DEPTH];

  // Entry storage; cleared by reset so a fresh job never sees stale operands.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign csr_rdata = mem_q[csr_raddr];
  assign seq_rdata = mem_q[seq_raddr];

endmodule

// File: rtl/mac_seq.sv
// mac_seq: CSR-controlled sequencer streaming operand pairs through an external
// mac (result = f1*f2 + a1), feeding the saturated result back as the next a1.
// Optional build macro MAC_SEQ_IRQ_EN adds the irq output and CTRL bit2 enable.
module mac_seq
  import mac_seq_pkg::*;
#(
  parameter int DEPTH   = 16,
  parameter int MAC_LAT = 1,
  parameter int ADDR_W  = 12,
  parameter int DATA_W  = 64
) (
  input  logic              clk,
  input  logic              arst,
  input  logic [ADDR_W-1:0] addr,
  input  logic              wen,
  input  logic              ren,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              waddr_error,
  output logic              raddr_error,
  output logic [F_W-1:0]    f1_dat,
  output logic [F_W-1:0]    f2_dat,
  output logic [ACC_W-1:0]  a1_dat,
  input  logic [RES_W-1:0]  result_dat,
  output logic              busy
`ifdef MAC_SEQ_IRQ_EN
  ,
  output logic              irq
`endif
);

  localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int WCNT_W = 8;

  state_e              state_q, state_d;
  logic [ACC_W-1:0]    acc_q, acc_d, a1_q, a1_d, init_q;
  logic [LEN_W-1:0]    idx_q, idx_d, n_q, n_d, len_q, n_start;
  logic [WCNT_W-1:0]   wcnt_q, wcnt_d;
  logic [F_W-1:0]      f1_q, f1_d, f2_q, f2_d;
  logic                done_q, done_d, ovf_q, ovf_d;
  logic [DATA_W-1:0]   rdata_q, rd_d;
  logic                waddr_err_q, raddr_err_q, rd_err, wr_err;
  logic [ENTRY_W-1:0]  csr_entry, seq_entry;
  logic [ADDR_W-1:0]   buf_off;
  logic                hit_ctrl, hit_status, hit_len, hit_init, hit_acc, buf_hit;
  logic                idle, start_req, abort_req, buf_we, w1c;
  sat_t                cap_sat;
  logic                unused_wdata;
`ifdef MAC_SEQ_IRQ_EN
  logic                irq_en_q, irq_q;
`endif

  // Address decode; buffer entries must be 8-byte aligned and inside DEPTH.
  assign buf_off    = addr - ADDR_W'(BUF_BASE);
  assign hit_ctrl   = (addr == ADDR_W'(CTRL_OFF));
  assign hit_status = (addr == ADDR_W'(STATUS_OFF));
  assign hit_len    = (addr == ADDR_W'(LEN_OFF));
  assign hit_init   = (addr == ADDR_W'(INIT_OFF));
  assign hit_acc    = (addr == ADDR_W'(ACC_OFF));
  assign buf_hit    = (addr[2:0] == 3'b000) && (addr >= ADDR_W'(BUF_BASE)) &&
                      (buf_off < ADDR_W'(8 * DEPTH));

  assign idle      = (state_q == S_IDLE);
  // ABORT beats START in the same write; START outside IDLE is silently ignored.
  assign start_req = wen && hit_ctrl && wdata[0] && !wdata[1] && idle;
  assign abort_req = wen && hit_ctrl && wdata[1] && !idle;
  assign w1c       = wen && hit_status;
  assign buf_we    = wen && buf_hit && idle;
  // ACC is read-only, so a write there is rejected like an unmapped one.
  assign wr_err    = wen && (!(hit_ctrl || hit_status || hit_len || hit_init || buf_hit) ||
                             hit_acc || (!idle && (hit_len || hit_init || buf_hit)));
  assign n_start   = (len_q > LEN_W'(DEPTH)) ? LEN_W'(DEPTH) : len_q;
  assign cap_sat   = sat24(result_dat);
  assign unused_wdata = ^wdata[DATA_W-1:28];

  mac_seq_opbuf #(.DEPTH(DEPTH), .IDX_W(IDX_W)) u_opbuf (
    .clk       (clk),
    .arst      (arst),
    .we        (buf_we),
    .waddr     (buf_off[IDX_W+2:3]),
    .wdata     ({wdata[27:16], wdata[11:0]}),
    .csr_raddr (buf_off[IDX_W+2:3]),
    .csr_rdata (csr_entry),
    .seq_raddr (idx_q[IDX_W-1:0]),
    .seq_rdata (seq_entry)
  );

  // FSM state register.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // FSM next-state logic; ABORT overrides every transition.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (start_req) state_d = (n_start == '0) ? S_DONE : S_ISSUE;
      S_ISSUE:   state_d = (MAC_LAT == 1) ? S_CAPTURE : S_WAIT;
      S_WAIT:    if (wcnt_q == WCNT_W'(MAC_LAT - 2)) state_d = S_CAPTURE;
      S_CAPTURE: state_d = ((idx_q + 1'b1) < n_q) ? S_ISSUE : S_DONE;
      S_DONE:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
    if (abort_req) state_d = S_IDLE;
  end

  // FSM outputs: operand issue, accumulator capture and status flags.
  always_comb begin
    acc_d  = acc_q;
    idx_d  = idx_q;
    n_d    = n_q;
    wcnt_d = wcnt_q;
    f1_d   = f1_q;
    f2_d   = f2_q;
    a1_d   = a1_q;
    done_d = done_q & ~(w1c & wdata[1]);
    ovf_d  = ovf_q & ~(w1c & wdata[2]);
    case (state_q)
      S_IDLE: begin
        if (start_req) begin
          acc_d = init_q;
          idx_d = '0;
          n_d   = n_start;
        end
      end
      S_ISSUE: begin
        f1_d   = seq_entry[F_W-1:0];
        f2_d   = seq_entry[ENTRY_W-1:F_W];
        a1_d   = acc_q;
        wcnt_d = '0;
      end
      S_WAIT:  wcnt_d = wcnt_q + 1'b1;
      S_CAPTURE: begin
        // An aborted element does not count as completed.
        if (!abort_req) begin
          acc_d = cap_sat.val;
          idx_d = idx_q + 1'b1;
          if (cap_sat.ovf) ovf_d = 1'b1;
        end
      end
      S_DONE:  if (!abort_req) done_d = 1'b1;
      default: ;
    endcase
  end

  // Datapath and status registers.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      acc_q  <= '0;
      idx_q  <= '0;
      n_q    <= '0;
      wcnt_q <= '0;
      f1_q   <= '0;
      f2_q   <= '0;
      a1_q   <= '0;
      done_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      idx_q  <= idx_d;
      n_q    <= n_d;
      wcnt_q <= wcnt_d;
      f1_q   <= f1_d;
      f2_q   <= f2_d;
      a1_q   <= a1_d;
      done_q <= done_d;
      ovf_q  <= ovf_d;
    end
  end

  // Read mux; unmapped addresses return zero and flag an error.
  always_comb begin
    rd_d   = '0;
    rd_err = 1'b0;
    if (hit_ctrl) begin
`ifdef MAC_SEQ_IRQ_EN
      rd_d[2] = irq_en_q;
`endif
    end else if (hit_status) begin
      rd_d[2:0] = {ovf_q, done_q, busy};
    end else if (hit_len) begin
      rd_d[LEN_W-1:0] = len_q;
    end else if (hit_init) begin
      rd_d = {{(DATA_W-ACC_W){init_q[ACC_W-1]}}, init_q};
    end else if (hit_acc) begin
      rd_d = {{(DATA_W-ACC_W){acc_q[ACC_W-1]}}, acc_q};
    end else if (buf_hit) begin
      rd_d[27:16] = csr_entry[ENTRY_W-1:F_W];
      rd_d[11:0]  = csr_entry[F_W-1:0];
    end else begin
      rd_err = 1'b1;
    end
  end

  // CSR configuration registers, read data and error pulses.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      len_q       <= '0;
      init_q      <= '0;
      rdata_q     <= '0;
      waddr_err_q <= 1'b0;
      raddr_err_q <= 1'b0;
    end else begin
      if (wen && hit_len && idle)  len_q  <= wdata[LEN_W-1:0];
      if (wen && hit_init && idle) init_q <= wdata[ACC_W-1:0];
      if (ren) rdata_q <= rd_d;
      waddr_err_q <= wr_err;
      raddr_err_q <= ren && rd_err;
    end
  end

`ifdef MAC_SEQ_IRQ_EN
  // Interrupt enable and level irq that follows done one cycle later.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      irq_en_q <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      if (wen && hit_ctrl) irq_en_q <= wdata[2];
      irq_q <= done_q & irq_en_q;
    end
  end
  assign irq = irq_q;
`endif

  assign busy        = !idle;
  assign rdata       = rdata_q;
  assign waddr_error = waddr_err_q;
  assign raddr_error = raddr_err_q;
  assign f1_dat      = f1_q;
  assign f2_dat      = f2_q;
  assign a1_dat      = a1_q;

endmodule

// File: tb/tb_mac_seq.sv
// tb_mac_seq: directed scoreboard bench for mac_seq with a combinational mac
// model (MAC_LAT=1). Reads and writes push expectations; a negedge monitor
// pops them when rdata / waddr_error become valid.
module tb_mac_seq;

  localparam int DEPTH = 16, MAC_LAT = 1, ADDR_W = 12, DATA_W = 64;
  localparam logic [11:0] A_CTRL = 12'h000, A_STAT = 12'h008, A_LEN = 12'h010;
  localparam logic [11:0] A_INIT = 12'h018, A_ACC = 12'h020;
`ifdef MAC_SEQ_IRQ_EN
  localparam logic [63:0] START_CMD = 64'h5;
`else
  localparam logic [63:0] START_CMD = 64'h1;
`endif

  logic              clk = 1'b0, arst = 1'b1;
  logic [ADDR_W-1:0] addr = '0;
  logic              wen = 1'b0, ren = 1'b0;
  logic [DATA_W-1:0] wdata = '0;
  logic [DATA_W-1:0] rdata;
  logic              waddr_error, raddr_error, busy;
  logic [11:0]       f1_dat, f2_dat;
  logic [23:0]       a1_dat;
  logic [24:0]       result_dat;
  logic signed [24:0] m_f1, m_f2, m_a1;
`ifdef MAC_SEQ_IRQ_EN
  logic              irq;
`endif

  int n_pass = 0, n_total = 0;
  int cyc;

  typedef struct { string name; logic [63:0] data; logic err; } rd_exp_t;
  typedef struct { string name; logic err; } wr_exp_t;
  rd_exp_t rd_q[$];
  wr_exp_t wr_q[$];
  logic ren_seen = 1'b0, wen_seen = 1'b0;

  always #5 clk = ~clk;

  // Reference mac: result = f1*f2 + a1, valid in the same cycle.
  assign m_f1 = 25'($signed(f1_dat));
  assign m_f2 = 25'($signed(f2_dat));
  assign m_a1 = 25'($signed(a1_dat));
  assign result_dat = m_f1 * m_f2 + m_a1;

  mac_seq #(.DEPTH(DEPTH), .MAC_LAT(MAC_LAT), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .arst(arst), .addr(addr), .wen(wen), .ren(ren), .wdata(wdata),
    .rdata(rdata), .waddr_error(waddr_error), .raddr_error(raddr_error),
    .f1_dat(f1_dat), .f2_dat(f2_dat), .a1_dat(a1_dat), .result_dat(result_dat),
    .busy(busy)
`ifdef MAC_SEQ_IRQ_EN
    , .irq(irq)
`endif
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [63:0] ent(input int f1, input int f2);
    return {36'b0, 12'(f2), 4'b0, 12'(f1)};
  endfunction

  // Monitor: note which strobes the DUT sampled, then check the responses.
  always @(posedge clk) begin
    ren_seen <= ren;
    wen_seen <= wen;
  end

  always @(negedge clk) begin
    rd_exp_t re;
    wr_exp_t we_e;
    if (ren_seen) begin
      if (rd_q.size() == 0) begin
        n_total++;
        $display("FAIL read_unexpected: rdata 0x%0h with no expectation queued", rdata);
      end else begin
        re = rd_q.pop_front();
        check({re.name, "_rdata"}, rdata, re.data);
        check({re.name, "_raddr_error"}, 64'(raddr_error), 64'(re.err));
      end
    end
    if (wen_seen) begin
      if (wr_q.size() == 0) begin
        n_total++;
        $display("FAIL write_unexpected: waddr_error %0b with no expectation queued", waddr_error);
      end else begin
        we_e = wr_q.pop_front();
        check({we_e.name, "_waddr_error"}, 64'(waddr_error), 64'(we_e.err));
      end
    end
  end

  task automatic wr(input logic [11:0] a, input logic [63:0] d, input logic err, input string name);
    wr_q.push_back('{name: name, err: err});
    addr = a; wdata = d; wen = 1'b1;
    @(negedge clk);
    wen = 1'b0;
  endtask

  task automatic rd(input logic [11:0] a, input logic [63:0] exp, input logic err, input string name);
    rd_q.push_back('{name: name, data: exp, err: err});
    addr = a; ren = 1'b1;
    @(negedge clk);
    ren = 1'b0;
  endtask

  task automatic load_entry(input int i, input int f1, input int f2);
    wr(12'h100 + 12'(8 * i), ent(f1, f2), 1'b0, "buf_wr");
  endtask

  // Count busy cycles starting from the current (first busy) cycle.
  task automatic run_wait(output int cycles);
    cycles = 0;
    while (busy === 1'b1 && cycles < 500) begin
      cycles++;
      @(negedge clk);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_total);
    $fatal(1);
  end

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    check("rst_busy", 64'(busy), 0);
    check("rst_f1", 64'(f1_dat), 0);
    check("rst_a1", 64'(a1_dat), 0);
    arst = 1'b0;
    @(negedge clk);
    rd(A_CTRL, 0, 0, "rst_ctrl");
    rd(A_STAT, 0, 0, "rst_status");
    rd(A_LEN, 0, 0, "rst_len");
    rd(A_ACC, 0, 0, "rst_acc");
    rd(12'h108, 0, 0, "rst_entry1");

    // Dot product: 10 + 2*(1+2+3+4) = 30
    for (int i = 0; i < 4; i++) load_entry(i, i + 1, 2);
    wr(A_INIT, 64'd10, 0, "init");
    wr(A_LEN, 64'd4, 0, "len");
    rd(12'h110, ent(3, 2), 0, "entry2_readback");
    wr(A_CTRL, START_CMD, 0, "start");
    run_wait(cyc);
    check("dot_busy_cycles", 64'(cyc), 9);
    rd(A_STAT, 64'h2, 0, "dot_status");
    rd(A_ACC, 64'd30, 0, "dot_acc");
`ifdef MAC_SEQ_IRQ_EN
    check("irq_set", 64'(irq), 1);
`endif
    wr(A_STAT, 64'h2, 0, "w1c_done");
    rd(A_STAT, 0, 0, "dot_status_clr");
`ifdef MAC_SEQ_IRQ_EN
    @(negedge clk);
    check("irq_clr", 64'(irq), 0);
`endif

    // Positive saturation: 8000000 + 4194304 -> 8388607
    load_entry(0, -2048, -2048);
    wr(A_INIT, 64'(8000000), 0, "init");
    wr(A_LEN, 64'd1, 0, "len");
    wr(A_CTRL, START_CMD, 0, "start");
    run_wait(cyc);
    check("sat_busy_cycles", 64'(cyc), 3);
    rd(A_STAT, 64'h6, 0, "sat_status");
    rd(A_ACC, 64'd8388607, 0, "sat_acc");
    wr(A_STAT, 64'h4, 0, "w1c_ovf");
    rd(A_STAT, 64'h2, 0, "sat_ovf_clr");
    wr(A_STAT, 64'h2, 0, "w1c_done");

    // Negative saturation: -8000000 - 4192256 -> -8388608
    load_entry(0, -2048, 2047);
    wr(A_INIT, 64'(-8000000), 0, "init");
    wr(A_CTRL, START_CMD, 0, "start");
    run_wait(cyc);
    rd(A_ACC, 64'(-8388608), 0, "negsat_acc");
    rd(A_STAT, 64'h6, 0, "negsat_status");
    wr(A_STAT, 64'h6, 0, "w1c_both");

    // LEN=0: DONE straight away, ACC=INIT
    wr(A_INIT, 64'd5, 0, "init");
    wr(A_LEN, 64'd0, 0, "len");
    wr(A_CTRL, START_CMD, 0, "start");
    run_wait(cyc);
    check("len0_busy_cycles", 64'(cyc), 1);
    rd(A_STAT, 64'h2, 0, "len0_status");
    rd(A_ACC, 64'd5, 0, "len0_acc");
    wr(A_STAT, 64'h2, 0, "w1c_done");

    // LEN=20 clamps to 16: sum 1..16 = 136
    for (int i = 0; i < 16; i++) load_entry(i, i + 1, 1);
    wr(A_INIT, 64'd0, 0, "init");
    wr(A_LEN, 64'd20, 0, "len");
    wr(A_CTRL, START_CMD, 0, "start");
    run_wait(cyc);
    check("len20_busy_cycles", 64'(cyc), 33);
    rd(A_ACC, 64'd136, 0, "len20_acc");
    rd(A_LEN, 64'd20, 0, "len20_len");
    wr(A_STAT, 64'h2, 0, "w1c_done");

    // Abort during the third ISSUE: elements 0 and 1 done -> 100+1+2
    wr(A_INIT, 64'd100, 0, "init");
    wr(A_LEN, 64'd8, 0, "len");
    wr(A_CTRL, START_CMD, 0, "start");
    repeat (4) @(negedge clk);
    wr(A_CTRL, 64'h2, 0, "abort");
    check("abort_busy", 64'(busy), 0);
    rd(A_STAT, 0, 0, "abort_status");
    rd(A_ACC, 64'd103, 0, "abort_acc");
    wr(A_CTRL, 64'h3, 0, "start_abort_idle");
    check("start_abort_busy", 64'(busy), 0);

    // Rejected accesses during a job; START while busy has no effect
    wr(A_INIT, 64'd0, 0, "init");
    wr(A_LEN, 64'd4, 0, "len");
    wr(A_CTRL, START_CMD, 0, "start");
    wr(12'h100, ent(7, 7), 1, "buf_wr_busy");
    wr(A_LEN, 64'd2, 1, "len_wr_busy");
    wr(A_CTRL, START_CMD, 0, "start_busy");
    run_wait(cyc);
    check("reject_busy_cycles", 64'(cyc), 6);
    rd(A_ACC, 64'd10, 0, "reject_acc");
    rd(12'h100, ent(1, 1), 0, "reject_entry0");
    rd(A_LEN, 64'd4, 0, "reject_len");
    rd(12'h080, 0, 1, "unmapped_rd");
    rd(12'h104, 0, 1, "misaligned_rd");
    wr(12'h080, 64'd5, 1, "unmapped_wr");
    wr(A_STAT, 64'h2, 0, "w1c_done");

    // Reset mid-job
    wr(A_INIT, 64'd7, 0, "init");
    wr(A_CTRL, START_CMD, 0, "start");
    @(negedge clk);
    arst = 1'b1;
    #1;
    check("midrst_busy", 64'(busy), 0);
    check("midrst_f1", 64'(f1_dat), 0);
    check("midrst_f2", 64'(f2_dat), 0);
    check("midrst_a1", 64'(a1_dat), 0);
    @(negedge clk);
    arst = 1'b0;
    @(negedge clk);
    rd(A_STAT, 0, 0, "midrst_status");
    rd(A_ACC, 0, 0, "midrst_acc");
    rd(A_LEN, 0, 0, "midrst_len");
    rd(12'h108, 0, 0, "midrst_entry1");
    for (int i = 0; i < 4; i++) load_entry(i, i + 1, 2);
    wr(A_INIT, 64'd10, 0, "init");
    wr(A_LEN, 64'd4, 0, "len");
    wr(A_CTRL, START_CMD, 0, "start");
    run_wait(cyc);
    check("post_rst_busy_cycles", 64'(cyc), 9);
    rd(A_ACC, 64'd30, 0, "post_rst_acc");
    rd(A_STAT, 64'h2, 0, "post_rst_status");

    repeat (2) @(negedge clk);
    check("rd_queue_drained", 64'(rd_q.size()), 0);
    check("wr_queue_drained", 64'(wr_q.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
